token_share_scheduler: RTL
==========================

Name: token_share_scheduler

Overview:
- Shares one output token stream between N_REQ token sources.
- Each source input pulse a[i] is multiplied by a per-source factor mult[i] and banked as pending credits in a per-source counter.
- A round-robin scheduler drains the counters onto a single output, at most one token per cycle, tagged with the source id.
- Generalises the token-doubler datapath to a multi-source, configurable-ratio front end. Per-source sticky overflow flags report counter saturation.

Parameters:
- N_REQ, 4, number of token sources (>= 2).
- CNT_W, 8, width of each pending-credit counter.
- MULT_W, 2, width of each multiplier field (ratio 0..2^MULT_W-1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low.
- en  input  1  grant enable; 0 stalls output, accumulation continues.
- clr_ovf  input  1  synchronous clear of all overflow flags.
- a  input  N_REQ  token pulses, one bit per source.
- mult  input  N_REQ*MULT_W  per-source multiplier; field i = mult[i*MULT_W +: MULT_W].
- b  output  1  registered output token.
- b_id  output  $clog2(N_REQ)  registered id of the source owning the current b token.
- overflow  output  N_REQ  sticky per-source saturation flags.
- busy  output  1  OR of (cnt[i] != 0), combinational from registers.

Behaviour:
- Reset (rst=0, async):
  - cnt[i]=0, b=0, b_id=0, overflow=0.
  - RR pointer ptr=N_REQ-1, so source 0 has first priority.
- Grant (combinational, from current registers):
  - Eligible set = {i : cnt[i] != 0}; gated entirely by en.
  - Search order ptr+1, ptr+2, ..., ptr (mod N_REQ); the first eligible index wins.
  - At most one grant per cycle.
- Per posedge, for every source i:
  - inc = a[i] ? mult[i] : 0; dec = (grant==i) ? 1 : 0.
  - sum = cnt[i] + inc - dec, computed at width CNT_W+MULT_W+1.
  - If sum > 2^CNT_W-1: cnt[i] = 2^CNT_W-1 and overflow[i] = 1. Otherwise cnt[i] = sum.
  - inc and dec on the same source in the same cycle are both applied.
- Outputs per posedge:
  - Grant present: b=1, b_id=grant, ptr=grant.
  - No grant: b=0, b_id=0, ptr unchanged.
- Latency: a[i]=1 sampled at edge k makes cnt[i] nonzero after edge k. The earliest corresponding b=1 is after edge k+1, i.e. 1 cycle minimum.
- Throughput:
  - One token per cycle total while busy and en=1.
  - A single active source with mult=1 and a=1 continuously keeps b=1 every cycle with no backlog growth.
- mult is sampled only on edges where a[i]=1; it is not latched. Changing mult affects only future pulses.
- mult[i]=0: pulses from source i are discarded (no credit, no overflow).
- Overflow flags:
  - Sticky: cleared only by reset or by clr_ovf=1 at an edge.
  - If clr_ovf and a new saturation occur at the same edge, set wins.
  - Saturated credits are lost; counting continues from max.
- en=0:
  - b=0, b_id=0, ptr frozen, counters only increment.
  - When en returns to 1, output resumes with the next RR grant.
- Conservation: with no overflow, total b pulses = Σ over pulses of mult[i]. Per-id counts of b_id match per-source credits.
- Reset mid-operation: all pending credits are discarded and b drops immediately (async).

Test Plan:
- Reset with rst=0 for 2 cycles, then rst=1 -> b=0, b_id=0, overflow=0, busy=0 throughout and after.
- Source 0 only, mult[0]=2, 100 cycles of a[0] random at 30%, then 200 idle cycles -> count(b) = 2*count(a[0]), all b_id=0, overflow=0, busy=0 at end.
- All sources, mult = {3,2,1,1}, single simultaneous pulse on all a -> 7 b pulses on consecutive cycles. b_id sequence 0,1,2,3,0,1,0 (exhausted sources skipped), then b=0.
- en=0 for 20 cycles while a[1] pulses 5 times with mult[1]=2 -> b stays 0, busy=1. Set en=1 -> exactly 10 consecutive b pulses with b_id=1.
- All a=1, all mult=2, 1000 cycles (CNT_W=8) -> overflow=4'b1111, each cnt holds at 255. clr_ovf with a=0 -> overflow=0 and draining continues.
- Source 2 mult=1, a[2]=1 for 50 cycles -> b=1 from the second cycle on with b_id=2, cnt[2] never exceeds 1, overflow[2]=0.

Source files
------------

// File: rtl/token_share_scheduler.sv
// Multi-source token scheduler: each source pulse banks mult[i] credits in a
// saturating counter; a round-robin arbiter drains one credit per cycle onto b.
module token_share_scheduler #(
    parameter int N_REQ  = 4,
    parameter int CNT_W  = 8,
    parameter int MULT_W = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clr_ovf,
    input  logic [N_REQ-1:0]          a,
    input  logic [N_REQ*MULT_W-1:0]   mult,
    output logic                      b,
    output logic [$clog2(N_REQ)-1:0]  b_id,
    output logic [N_REQ-1:0]          overflow,
    output logic                      busy
);
    localparam int IW    = $clog2(N_REQ);
    localparam int SUM_W = CNT_W + MULT_W + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(MULT_W + 1){1'b0}}, {CNT_W{1'b1}}};

    logic [N_REQ-1:0] nonzero;
    logic             grant_valid;
    logic [IW-1:0]    grant_idx;
    logic [IW-1:0]    ptr_reg;
    logic             b_reg;
    logic [IW-1:0]    b_id_reg;

    // First eligible source after the last winner takes this cycle's slot.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (en && !grant_valid && nonzero[(int'(ptr_reg) + k) % N_REQ]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'((int'(ptr_reg) + k) % N_REQ);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_src
            logic [CNT_W-1:0] cnt_reg;
            logic             ovf_reg;
            logic [SUM_W-1:0] sum;
            logic             sat;

            // Wide sum so credit added and drained in one cycle never wraps.
            always_comb begin
                sum = SUM_W'(cnt_reg);
                if (a[gi]) begin
                    sum = sum + SUM_W'(mult[gi*MULT_W +: MULT_W]);
                end
                if (grant_valid && (grant_idx == IW'(gi))) begin
                    sum = sum - SUM_W'(1);
                end
                sat = (sum > CNT_MAX);
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= '0;
                    ovf_reg <= 1'b0;
                end else begin
                    cnt_reg <= sat ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
                    ovf_reg <= sat | (ovf_reg & ~clr_ovf);
                end
            end

            assign nonzero[gi]  = (cnt_reg != '0);
            assign overflow[gi] = ovf_reg;
        end
    endgenerate

    // Pointer resets to the last index so source 0 is searched first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_reg    <= 1'b0;
            b_id_reg <= '0;
            ptr_reg  <= IW'(N_REQ - 1);
        end else begin
            b_reg    <= grant_valid;
            b_id_reg <= grant_valid ? grant_idx : '0;
            if (grant_valid) begin
                ptr_reg <= grant_idx;
            end
        end
    end

    assign b    = b_reg;
    assign b_id = b_id_reg;
    assign busy = |nonzero;

endmodule
